// File: rtl/corrode_grid_pkg.sv
// -----------------------------------------------------------------------------
// corrode_grid_pkg
// Shared definitions for the corrode_grid block-decision engine:
//   - default sensor geometry (OV5640_X/Y), ROI corners (PIC_X1..PIC_Y2) and
//     block edge (CORROSION_SIZE), used as the top-level parameter defaults
//   - FSM state type
//   - idx_w(): index width helper that never returns 0
// -----------------------------------------------------------------------------
package corrode_grid_pkg;

  localparam int OV5640_X       = 640;
  localparam int OV5640_Y       = 480;
  localparam int PIC_X1         = 80;
  localparam int PIC_X2         = 559;
  localparam int PIC_Y1         = 0;
  localparam int PIC_Y2         = 479;
  localparam int CORROSION_SIZE = 8;

  typedef enum logic {
    ST_WAIT_SOF = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  // Width of an index into n items; a single item still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/corrode_grid_pos.sv
// -----------------------------------------------------------------------------
// corrode_grid_pos
// Raster / ROI / block position tracker. The registers hold the position of
// the next expected pixel; sof_i overrides that with (0,0) so the pixel that
// carries start-of-frame is decoded as the first pixel of a fresh frame.
//
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   adv_i              : current pixel is accepted, step to the next position
//   sof_i              : current pixel is (0,0) of a new frame
//   in_roi_o           : current pixel lies inside the ROI
//   blk_last_o         : current pixel is the bottom-right pixel of its block
//   frm_last_o         : ... and that block is the last block of the frame
//   bx_o, by_o         : block column / row of the current pixel
// -----------------------------------------------------------------------------
module corrode_grid_pos
  import corrode_grid_pkg::*;
#(
  parameter int IMG_W = OV5640_X,
  parameter int IMG_H = OV5640_Y,
  parameter int X1    = PIC_X1,
  parameter int X2    = PIC_X2,
  parameter int Y1    = PIC_Y1,
  parameter int Y2    = PIC_Y2,
  parameter int BLK   = CORROSION_SIZE,
  localparam int NBX  = (X2 - X1 + 1) / BLK,
  localparam int NBY  = (Y2 - Y1 + 1) / BLK,
  localparam int BXW  = idx_w(NBX),
  localparam int BYW  = idx_w(NBY)
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           adv_i,
  input  logic           sof_i,
  output logic           in_roi_o,
  output logic           blk_last_o,
  output logic           frm_last_o,
  output logic [BXW-1:0] bx_o,
  output logic [BYW-1:0] by_o
);

  localparam int XW = idx_w(IMG_W);
  localparam int YW = idx_w(IMG_H);
  localparam int SW = idx_w(BLK);

  localparam logic [XW-1:0]  X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(IMG_H - 1);
  localparam logic [XW-1:0]  X1_L    = XW'(X1);
  localparam logic [XW-1:0]  X2_L    = XW'(X2);
  localparam logic [YW-1:0]  Y1_L    = YW'(Y1);
  localparam logic [YW-1:0]  Y2_L    = YW'(Y2);
  localparam logic [SW-1:0]  S_LAST  = SW'(BLK - 1);
  localparam logic [BXW-1:0] BX_LAST = BXW'(NBX - 1);
  localparam logic [BYW-1:0] BY_LAST = BYW'(NBY - 1);
  // ROI membership of column 0 / row 0, needed when a line or frame restarts.
  localparam logic           COL0    = (X1 == 0);
  localparam logic           ROW0    = (Y1 == 0);

  logic [XW-1:0]  x_q, x_d, cur_x;
  logic [YW-1:0]  y_q, y_d, cur_y;
  logic           col_q, col_d, cur_col;
  logic           row_q, row_d, cur_row;
  logic [SW-1:0]  sx_q, sx_d, cur_sx;
  logic [SW-1:0]  sy_q, sy_d, cur_sy;
  logic [BXW-1:0] bx_q, bx_d, cur_bx;
  logic [BYW-1:0] by_q, by_d, cur_by;
  logic           x_wrap, y_wrap, sx_last, sy_last, bx_last, by_last;

  always_comb begin
    cur_x   = sof_i ? '0   : x_q;
    cur_y   = sof_i ? '0   : y_q;
    cur_col = sof_i ? COL0 : col_q;
    cur_row = sof_i ? ROW0 : row_q;
    cur_sx  = sof_i ? '0   : sx_q;
    cur_sy  = sof_i ? '0   : sy_q;
    cur_bx  = sof_i ? '0   : bx_q;
    cur_by  = sof_i ? '0   : by_q;

    x_wrap  = (cur_x == X_LAST);
    y_wrap  = (cur_y == Y_LAST);
    sx_last = (cur_sx == S_LAST);
    sy_last = (cur_sy == S_LAST);
    bx_last = (cur_bx == BX_LAST);
    by_last = (cur_by == BY_LAST);

    x_d   = x_q;
    y_d   = y_q;
    col_d = col_q;
    row_d = row_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    bx_d  = bx_q;
    by_d  = by_q;

    if (adv_i) begin
      x_d   = x_wrap ? '0 : cur_x + 1'b1;
      // ROI column flag tracks the next pixel incrementally; equality only,
      // so a zero-based ROI edge needs no constant compare.
      col_d = x_wrap ? COL0 :
              (cur_x == X2_L) ? 1'b0 :
              (x_d == X1_L)   ? 1'b1 : cur_col;
      sx_d  = cur_sx;
      bx_d  = cur_bx;
      if (cur_col) begin
        sx_d = sx_last ? '0 : cur_sx + 1'b1;
        if (sx_last) bx_d = bx_last ? '0 : cur_bx + 1'b1;
      end

      y_d   = cur_y;
      row_d = cur_row;
      sy_d  = cur_sy;
      by_d  = cur_by;
      if (x_wrap) begin
        y_d   = y_wrap ? '0 : cur_y + 1'b1;
        row_d = y_wrap ? ROW0 :
                (cur_y == Y2_L) ? 1'b0 :
                (y_d == Y1_L)   ? 1'b1 : cur_row;
        if (cur_row) begin
          sy_d = sy_last ? '0 : cur_sy + 1'b1;
          if (sy_last) by_d = by_last ? '0 : cur_by + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      col_q <= 1'b0;
      row_q <= 1'b0;
      sx_q  <= '0;
      sy_q  <= '0;
      bx_q  <= '0;
      by_q  <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      col_q <= col_d;
      row_q <= row_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      bx_q  <= bx_d;
      by_q  <= by_d;
    end
  end

  assign in_roi_o   = cur_col & cur_row;
  assign blk_last_o = in_roi_o & sx_last & sy_last;
  assign frm_last_o = blk_last_o & bx_last & by_last;
  assign bx_o       = cur_bx;
  assign by_o       = cur_by;

endmodule

// File: rtl/corrode_grid.sv
// -----------------------------------------------------------------------------
// corrode_grid
// Splits the ROI of a binary raster stream into BLK x BLK blocks, counts the
// black pixels of each block and emits one erode/dilate decision per block.
//
// State table:
//   ST_WAIT_SOF | pixels discarded until i_valid & i_sof
//   ST_RUN      | pixels accumulated; i_sof restarts the frame at (0,0)
//
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   i_sof, i_valid     : frame start qualifier, pixel strobe
//   i_wb               : pixel, 0 = black, 1 = white
//   i_thresh, i_mode   : decision threshold, 0 = erode / 1 = dilate
//                        (both sampled on the last pixel of a block)
//   o_valid            : one-cycle decision strobe
//   o_wb, o_bx, o_by   : decision and its block column / row
//   o_frame_done       : strobe with the last block of the frame
//   o_cnt              : black count N of the block, only when
//                        CORRODE_GRID_CNT_OUT_EN is defined
// -----------------------------------------------------------------------------
module corrode_grid
  import corrode_grid_pkg::*;
#(
  parameter int IMG_W   = OV5640_X,
  parameter int IMG_H   = OV5640_Y,
  parameter int X1      = PIC_X1,
  parameter int X2      = PIC_X2,
  parameter int Y1      = PIC_Y1,
  parameter int Y2      = PIC_Y2,
  parameter int BLK     = CORROSION_SIZE,
  localparam int NBX    = (X2 - X1 + 1) / BLK,
  localparam int NBY    = (Y2 - Y1 + 1) / BLK,
  localparam int CNT_W  = $clog2(BLK * BLK + 1),
  localparam int BXW    = idx_w(NBX),
  localparam int BYW    = idx_w(NBY)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             i_sof,
  input  logic             i_valid,
  input  logic             i_wb,
  input  logic [CNT_W-1:0] i_thresh,
  input  logic             i_mode,
`ifdef CORRODE_GRID_CNT_OUT_EN
  output logic [CNT_W-1:0] o_cnt,
`endif
  output logic             o_valid,
  output logic             o_wb,
  output logic [BXW-1:0]   o_bx,
  output logic [BYW-1:0]   o_by,
  output logic             o_frame_done
);

  localparam logic [CNT_W-1:0] BB   = CNT_W'(BLK * BLK);
  localparam logic [CNT_W:0]   BB_X = (CNT_W + 1)'(BLK * BLK);

  state_t         state_q, state_d;
  logic           sof_acc, accept, black;
  logic           in_roi, blk_last, frm_last;
  logic [BXW-1:0] bx;
  logic [BYW-1:0] by;

  logic [CNT_W-1:0] acc_q [NBX];
  logic [CNT_W-1:0] acc_d [NBX];
  logic [CNT_W-1:0] base, n;
  logic [CNT_W:0]   sum;

  logic             valid_q, valid_d;
  logic             wb_q, wb_d;
  logic [BXW-1:0]   bx_q, bx_d;
  logic [BYW-1:0]   by_q, by_d;
  logic             fd_q, fd_d;

  assign sof_acc = i_valid & i_sof;
  assign accept  = i_valid & (i_sof | (state_q == ST_RUN));
  assign black   = ~i_wb;

  corrode_grid_pos #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .X1    (X1),
    .X2    (X2),
    .Y1    (Y1),
    .Y2    (Y2),
    .BLK   (BLK)
  ) u_pos (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .adv_i      (accept),
    .sof_i      (sof_acc),
    .in_roi_o   (in_roi),
    .blk_last_o (blk_last),
    .frm_last_o (frm_last),
    .bx_o       (bx),
    .by_o       (by)
  );

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_SOF: if (sof_acc) state_d = ST_RUN;
      ST_RUN:      state_d = ST_RUN;
      default:     state_d = ST_WAIT_SOF;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_WAIT_SOF;
    else            state_q <= state_d;
  end

  // Accumulators and block decision
  always_comb begin
    acc_d = acc_q;
    // A start-of-frame pixel sees empty accumulators even though the clear
    // only lands at the clock edge.
    base  = sof_acc ? '0 : acc_q[bx];
    sum   = {1'b0, base} + {{CNT_W{1'b0}}, black};
    n     = (sum > BB_X) ? BB : sum[CNT_W-1:0];

    if (accept) begin
      if (sof_acc) begin
        for (int i = 0; i < NBX; i++) acc_d[i] = '0;
      end
      if (in_roi) acc_d[bx] = blk_last ? '0 : n;
    end

    valid_d = accept & blk_last;
    fd_d    = accept & frm_last;
    wb_d    = 1'b0;
    bx_d    = bx_q;
    by_d    = by_q;
    if (valid_d) begin
      wb_d = i_mode ? ((BB - n) > i_thresh) : (n <= i_thresh);
      bx_d = bx;
      by_d = by;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NBX; i++) acc_q[i] <= '0;
      valid_q <= 1'b0;
      wb_q    <= 1'b0;
      bx_q    <= '0;
      by_q    <= '0;
      fd_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NBX; i++) acc_q[i] <= acc_d[i];
      valid_q <= valid_d;
      wb_q    <= wb_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      fd_q    <= fd_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_wb         = wb_q;
  assign o_bx         = bx_q;
  assign o_by         = by_q;
  assign o_frame_done = fd_q;

`ifdef CORRODE_GRID_CNT_OUT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   cnt_q <= '0;
    else if (valid_d) cnt_q <= n;
  end

  assign o_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_corrode_grid.sv
`timescale 1ns/1ps
module tb_corrode_grid;

  // Reduced geometry keeps full frames short: 4 x 3 blocks of 8x8 in a 48x32 image.
  localparam int IW = 48, IH = 32, PX1 = 8, PX2 = 39, PY1 = 4, PY2 = 27, B = 8;
  localparam int NBX = (PX2 - PX1 + 1) / B, NBY = (PY2 - PY1 + 1) / B;
  localparam int BB = B * B, CW = $clog2(BB + 1);
`ifdef CORRODE_GRID_CNT_OUT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, sof = 1'b0, vld = 1'b0, wb = 1'b0, mode = 1'b0;
  logic [CW-1:0] thr = '0;
  logic ov, owb, ofd;
  logic [1:0] obx, oby;
  int ocnt_i;
`ifdef CORRODE_GRID_CNT_OUT_EN
  logic [CW-1:0] ocnt;
  assign ocnt_i = int'(ocnt);
`else
  assign ocnt_i = 0;
`endif

  corrode_grid #(
    .IMG_W(IW), .IMG_H(IH), .X1(PX1), .X2(PX2), .Y1(PY1), .Y2(PY2), .BLK(B)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .i_sof        (sof),
    .i_valid      (vld),
    .i_wb         (wb),
    .i_thresh     (thr),
    .i_mode       (mode),
`ifdef CORRODE_GRID_CNT_OUT_EN
    .o_cnt        (ocnt),
`endif
    .o_valid      (ov),
    .o_wb         (owb),
    .o_bx         (obx),
    .o_by         (oby),
    .o_frame_done (ofd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic wb; int bx; int by; logic fd; int cnt; int cyc;
  } pulse_t;

  pulse_t exp_q[$], got_q[$];
  int n_cmp = 0, n_bad = 0, idle_bad = 0;

  logic pix  [IH][IW];
  int   thr_a[IH][IW];
  logic md_a [IH][IW];

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ov) begin
      pulse_t p;
      p.wb = owb; p.bx = int'(obx); p.by = int'(oby); p.fd = ofd;
      p.cnt = ocnt_i; p.cyc = cyc;
      got_q.push_back(p);
    end else if (owb || ofd) begin
      idle_bad++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int blk_black(input int bx, input int by);
    int s = 0;
    for (int yy = 0; yy < B; yy++)
      for (int xx = 0; xx < B; xx++)
        if (!pix[PY1 + by * B + yy][PX1 + bx * B + xx]) s++;
    return s;
  endfunction

  function automatic logic dec(input int nb, input int t, input logic m);
    return m ? ((BB - nb) > t) : (nb <= t);
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic fill_const(input logic w, input int t, input logic m);
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) begin
        pix[y][x] = w; thr_a[y][x] = t; md_a[y][x] = m;
      end
  endtask

  task automatic fill_rand();
    int dens;
    dens = int'($urandom_range(90, 10));
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) begin
        pix[y][x]   = (int'($urandom_range(99)) >= dens);
        thr_a[y][x] = int'($urandom_range(BB + 2));
        md_a[y][x]  = 1'($urandom);
      end
  endtask

  // Drives npix raster pixels from the arrays; gap cycles carry junk on all
  // other inputs. Expected pulses are queued only for sof-started frames.
  task automatic drive(input int npix, input int gap_pct, input bit with_sof);
    int p, x, y, bx, by, nb;
    pulse_t e;
    p = 0;
    while (p < npix) begin
      @(posedge clk); #1;
      if (int'($urandom_range(99)) < gap_pct) begin
        vld = 1'b0; wb = 1'($urandom); sof = 1'($urandom);
        thr = CW'($urandom); mode = 1'($urandom);
      end else begin
        x = p % IW; y = (p / IW) % IH;
        vld = 1'b1; sof = with_sof && (p == 0);
        wb = pix[y][x]; thr = CW'(thr_a[y][x]); mode = md_a[y][x];
        if (x >= PX1 && x <= PX2 && y >= PY1 && y <= PY2 &&
            (x - PX1) % B == B - 1 && (y - PY1) % B == B - 1) begin
          bx = (x - PX1) / B; by = (y - PY1) / B; nb = blk_black(bx, by);
          e.wb = dec(nb, thr_a[y][x], md_a[y][x]);
          e.bx = bx; e.by = by;
          e.fd = (bx == NBX - 1) && (by == NBY - 1);
          e.cnt = HAS_CNT ? nb : 0;
          e.cyc = cyc + 1;
          if (with_sof) exp_q.push_back(e);
        end
        p++;
      end
    end
    @(posedge clk); #1;
    vld = 1'b0; sof = 1'b0;
  endtask

  task automatic check_model(input string tag);
    pulse_t e, g;
    int k;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_pulse_count"}, got_q.size(), exp_q.size());
    k = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g.wb !== e.wb || g.bx != e.bx || g.by != e.by || g.fd !== e.fd ||
          g.cnt != e.cnt || g.cyc != e.cyc) begin
        n_bad++;
        $display("FAIL %s pulse%0d: got wb=%0b bx=%0d by=%0d fd=%0b cnt=%0d cyc=%0d expected wb=%0b bx=%0d by=%0d fd=%0b cnt=%0d cyc=%0d",
                 tag, k, g.wb, g.bx, g.by, g.fd, g.cnt, g.cyc,
                 e.wb, e.bx, e.by, e.fd, e.cnt, e.cyc);
      end
      k++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  // ---------------- table of single-block decisions ----------------
  typedef struct {
    int nblk; bit last_blk; int t; bit m; bit ewb;
  } vec_t;
  vec_t vt[10];

  int seq_a[$], seq_b[$];
  int nfd, nwb1, diff;

  initial begin
    vt[0] = '{5, 1, 4, 0, 0};
    vt[1] = '{5, 1, 5, 0, 1};
    vt[2] = '{0, 0, 0, 0, 1};
    vt[3] = '{64, 1, 63, 0, 0};
    vt[4] = '{64, 1, 64, 0, 1};
    vt[5] = '{0, 0, 63, 1, 1};
    vt[6] = '{0, 0, 64, 1, 0};
    vt[7] = '{64, 1, 0, 1, 0};
    vt[8] = '{32, 0, 31, 1, 1};
    vt[9] = '{33, 1, 31, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(ov), 0);
    chk("rst_wb", int'(owb), 0);
    chk("rst_bx", int'(obx), 0);
    chk("rst_by", int'(oby), 0);
    chk("rst_fd", int'(ofd), 0);
    if (HAS_CNT) chk("rst_cnt", ocnt_i, 0);
    rst_n = 1'b1;

    // Pixels before any start-of-frame are discarded.
    fill_const(1'b0, 64, 1'b0);
    drive(600, 0, 1'b0);
    repeat (4) @(posedge clk);
    chk("wait_sof_silent", got_q.size(), 0);
    got_q.delete();

    // Block (0,0) only; each vector restarts the frame with a fresh sof.
    for (int v = 0; v < 10; v++) begin
      fill_const(1'b1, vt[v].t, vt[v].m);
      for (int i = 0; i < vt[v].nblk - (vt[v].last_blk ? 1 : 0); i++)
        pix[PY1 + i / B][PX1 + i % B] = 1'b0;
      if (vt[v].last_blk) pix[PY1 + B - 1][PX1 + B - 1] = 1'b0;
      drive((PY1 + B - 1) * IW + PX1 + B, 0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      exp_q.delete();
      n_cmp++;
      if (got_q.size() != 1 || got_q[0].wb !== vt[v].ewb || got_q[0].bx != 0 ||
          got_q[0].by != 0 || (HAS_CNT && got_q[0].cnt != vt[v].nblk)) begin
        n_bad++;
        if (got_q.size() == 0)
          $display("FAIL vec%0d: got no pulse expected wb=%0b", v, vt[v].ewb);
        else
          $display("FAIL vec%0d: got n=%0d wb=%0b bx=%0d by=%0d cnt=%0d expected n=1 wb=%0b bx=0 by=0 cnt=%0d",
                   v, got_q.size(), got_q[0].wb, got_q[0].bx, got_q[0].by,
                   got_q[0].cnt, vt[v].ewb, vt[v].nblk);
      end
      got_q.delete();
    end

    // All-white frame, thresh 0, erode
    fill_const(1'b1, 0, 1'b0);
    drive(IW * IH, 0, 1'b1);
    repeat (4) @(posedge clk);
    nfd = 0; nwb1 = 0;
    foreach (got_q[i]) begin
      if (got_q[i].fd) begin
        nfd++;
        chk("white_fd_pos", got_q[i].bx * 16 + got_q[i].by, (NBX - 1) * 16 + NBY - 1);
      end
      if (got_q[i].wb) nwb1++;
    end
    chk("white_fd_count", nfd, 1);
    chk("white_wb1_count", nwb1, NBX * NBY);
    check_model("white");

    // All-black frame, thresh 0, dilate
    fill_const(1'b0, 0, 1'b1);
    drive(IW * IH, 0, 1'b1);
    check_model("black");

    // Random frame without and with gaps: identical decision sequence.
    fill_rand();
    drive(IW * IH, 0, 1'b1);
    repeat (4) @(posedge clk);
    foreach (got_q[i]) seq_a.push_back({got_q[i].wb, got_q[i].bx[7:0], got_q[i].by[7:0]});
    check_model("rand_nogap");
    drive(IW * IH, 50, 1'b1);
    repeat (4) @(posedge clk);
    foreach (got_q[i]) seq_b.push_back({got_q[i].wb, got_q[i].bx[7:0], got_q[i].by[7:0]});
    check_model("rand_gap");
    diff = (seq_a.size() != seq_b.size()) ? 1 : 0;
    foreach (seq_a[i]) if (i < seq_b.size() && seq_a[i] != seq_b[i]) diff = 1;
    chk("gap_seq_equal", diff, 0);

    // Start-of-frame in the middle of block row 1
    fill_rand();
    drive(15 * IW + 7, 0, 1'b1);
    check_model("partial");
    fill_rand();
    drive(IW * IH, 0, 1'b1);
    check_model("resof");

    // Reset mid-frame at (20,12), then pixels without sof, then a new frame
    fill_rand();
    drive(12 * IW + 20, 0, 1'b1);
    check_model("pre_reset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", int'(ov), 0);
    chk("midrst_bxby", int'(obx) * 4 + int'(oby), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand();
    drive(600, 50, 1'b0);
    repeat (4) @(posedge clk);
    chk("post_reset_silent", got_q.size(), 0);
    got_q.delete();
    drive(IW * IH, 30, 1'b1);
    check_model("after_reset");

    chk("idle_outputs_low", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
